ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Push/pop FIFO controller sitting directly upstream of the 4Kx128 synchronous dual-port RAM.
//  Converts producer push and consumer pop handshakes into RAM write/read strobes and addresses.
//  Keeps binary wrap-bit pointers, an occupancy count, full/empty and sticky error flags.
//  Returns read data with valid, aligned to the RAM's 1-cycle read latency.
// PARAMETERS
//  DATA_W   128   data word width; matches the RAM word.
//  ADDR_W   12    RAM address width; DEPTH = 2**ADDR_W = 4096 entries.
//  AF_LVL   4092  almost_full threshold, count >= AF_LVL (ALMOST_FLAGS_EN only).
//  AE_LVL   4     almost_empty threshold, count <= AE_LVL (ALMOST_FLAGS_EN only).
// PORTS
//  clock         in   1         single clock; all flops on the rising edge.
//  reset         in   1         synchronous, active-high.
//  push          in   1         producer write request.
//  push_data     in   DATA_W    word to store.
//  full          out  1         count == DEPTH.
//  pop           in   1         consumer read request.
//  pop_data      out  DATA_W    read word; driven directly from ram_data_out.
//  pop_valid     out  1         pop_data valid this cycle.
//  empty         out  1         count == 0.
//  count         out  ADDR_W+1  occupancy, 0..DEPTH.
//  overflow      out  1         sticky: push seen while full.
//  underflow     out  1         sticky: pop seen while empty.
//  ram_write_en  out  1         to RAM write_en.
//  ram_wr_addr   out  ADDR_W    to RAM wr_addr.
//  ram_data_in   out  DATA_W    to RAM top_data_in.
//  ram_read_en   out  1         to RAM read_en.
//  ram_rd_addr   out  ADDR_W    to RAM rd_addr.
//  ram_data_out  in   DATA_W    from RAM top_data_out; valid 1 clock after ram_read_en.
// BEHAVIOUR
//  - Reset: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, pop_valid = 0, overflow = 0, underflow = 0.
//    RAM contents are not cleared. Reset mid-operation discards in-flight pop_valid on the next edge.
//  - Pointers are ADDR_W+1 bits (MSB = wrap bit). ram_wr_addr = wr_ptr[ADDR_W-1:0]; ram_rd_addr = rd_ptr likewise.
//  - push_acc = push & ~full; pop_acc = pop & ~empty. Both flags come from registered count.
//  - RAM strobes are combinational, with no added latency:
//    - ram_write_en = push_acc, ram_data_in = push_data.
//    - ram_read_en = pop_acc.
//  - On push_acc, wr_ptr += 1. On pop_acc, rd_ptr += 1. Both wrap 4095 -> 0 and toggle the wrap bit.
//  - count next value: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
//  - Read latency 1: pop_valid(t+1) = pop_acc(t); pop_data(t+1) = word at rd_addr(t).
//  - Simultaneous push and pop are legal at any non-boundary occupancy; both are accepted.
//  - Empty: pop is rejected with no RAM read and underflow set. A same-cycle push is still accepted.
//    There is no write-to-read bypass; the first word is poppable the cycle after its push.
//  - Full: push is rejected with no RAM write and overflow set. A same-cycle pop is accepted, so full clears next cycle.
//  - Same-address read/write cannot occur: it would require count == 0 with a pop, or count == DEPTH with a push.
//  - overflow/underflow stay set until reset.
// CONFIGURATION
//  ALMOST_FLAGS_EN defined:
//    - adds output ports almost_full (count >= AF_LVL) and almost_empty (count <= AE_LVL).
//    - both are registered, consistent with count. Reset values: almost_full = 0, almost_empty = 1.
//  ALMOST_FLAGS_EN undefined: ports, logic and AF_LVL/AE_LVL usage are absent. All other behaviour is identical.
// TESTING
//  1. reset=1 for 2 cycles -> empty=1, full=0, count=0, pop_valid=0, overflow=0, underflow=0.
//  2. push 0xA5..A5 then pop next cycle -> ram_wr_addr=0 with write_en; ram_rd_addr=0 with read_en;
//     pop_valid=1 one cycle after the pop with pop_data=0xA5..A5; count 0->1->0.
//  3. pop while empty -> ram_read_en=0, underflow=1 and stays 1; count stays 0.
//  4. 4096 pushes of data=index -> full=1, count=4096; extra push gives ram_write_en=0, overflow=1;
//     then 4096 pops return 0..4095 in order; empty=1.
//  5. Preload 10 words, then push+pop every cycle for 5000 cycles -> count stays 10;
//     ram_wr_addr wraps 4095->0; data order preserved.
//  6. Full and push+pop same cycle -> pop accepted, push rejected, overflow=1, count=4095.
//     With ALMOST_FLAGS_EN: almost_full=1 at count 4092, almost_empty=1 at count 4.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO controller driving a 1-cycle-latency dual-port RAM.
// Define ALMOST_FLAGS_EN to add registered almost_full/almost_empty outputs.
module ram_fifo_ctrl #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
`ifdef ALMOST_FLAGS_EN
    ,
    parameter int AF_LVL = 4092,
    parameter int AE_LVL = 4
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
`ifdef ALMOST_FLAGS_EN
    output logic              almost_full,
    output logic              almost_empty,
`endif
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic            pop_valid_q, pop_valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic            push_acc, pop_acc;
`ifdef ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] AF_C = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C = AE_LVL[ADDR_W:0];
    logic            almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
`endif
    always_comb begin
        push_acc    = push & ~full;
        pop_acc     = pop & ~empty;
        wr_ptr_d    = push_acc ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d    = pop_acc ? rd_ptr_q + ONE : rd_ptr_q;
        count_d     = (push_acc & ~pop_acc) ? count_q + ONE :
                      (pop_acc & ~push_acc) ? count_q - ONE : count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
`ifdef ALMOST_FLAGS_EN
        almost_full_d  = count_d >= AF_C;
        almost_empty_d = count_d <= AE_C;
`endif
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef ALMOST_FLAGS_EN
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef ALMOST_FLAGS_EN
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
`endif
        end
    end
    assign full         = count_q == DEPTH;
    assign empty        = count_q == '0;
    assign count        = count_q;
    assign pop_valid    = pop_valid_q;
    assign pop_data     = ram_data_out;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign ram_write_en = push_acc;
    assign ram_wr_addr  = wr_ptr_q[ADDR_W-1:0];
    assign ram_data_in  = push_data;
    assign ram_read_en  = pop_acc;
    assign ram_rd_addr  = rd_ptr_q[ADDR_W-1:0];
`ifdef ALMOST_FLAGS_EN
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: randomized bench for ram_fifo_ctrl against a queue-based FIFO model and a behavioural RAM.
module tb_ram_fifo_ctrl;
    localparam int DW = 128;
    localparam int AW = 12;
    localparam int DEPTH = 4096;
    logic          clock = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0;
    logic [DW-1:0] push_data = '0, pop_data, ram_data_in, ram_data_out;
    logic          full, empty, pop_valid, overflow, underflow, ram_write_en, ram_read_en;
    logic [AW:0]   count;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
`ifdef ALMOST_FLAGS_EN
    logic          almost_full, almost_empty;
`endif
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] q[$];
    int            wr_total, rd_total, n_chk, n_pass;
    logic          m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_data;

    ram_fifo_ctrl dut (
        .clock(clock), .reset(reset), .push(push), .push_data(push_data), .full(full),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow),
`ifdef ALMOST_FLAGS_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .ram_write_en(ram_write_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_read_en(ram_read_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_write_en) mem[ram_wr_addr] <= ram_data_in;
        if (ram_read_en) rd_q <= mem[ram_rd_addr];
    end
    assign ram_data_out = rd_q;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_state();
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
        check("pop_valid", pop_valid, m_valid);
        if (m_valid) check("pop_data", pop_data, m_data);
`ifdef ALMOST_FLAGS_EN
        check("almost_full", almost_full, q.size() >= 4092);
        check("almost_empty", almost_empty, q.size() <= 4);
`endif
    endtask

    task automatic step(input logic p, input logic r, input logic [DW-1:0] d);
        logic pa, ra;
        @(negedge clock);
        push = p; pop = r; push_data = d;
        pa = p && q.size() < DEPTH;
        ra = r && q.size() > 0;
        #1;
        check("ram_write_en", ram_write_en, pa);
        check("ram_read_en", ram_read_en, ra);
        if (pa) begin
            check("ram_wr_addr", ram_wr_addr, wr_total % DEPTH);
            check("ram_data_in", ram_data_in, d);
        end
        if (ra) check("ram_rd_addr", ram_rd_addr, rd_total % DEPTH);
        m_ovf |= p && q.size() == DEPTH;
        m_unf |= r && q.size() == 0;
        m_valid = ra;
        if (ra) begin m_data = q.pop_front(); rd_total++; end
        if (pa) begin q.push_back(d); wr_total++; end
        @(posedge clock);
        #1;
        check_state();
    endtask

    task automatic do_reset(input logic hold_pop);
        @(negedge clock);
        reset = 1'b1; push = 1'b0; pop = hold_pop;
        repeat (2) @(posedge clock);
        #1;
        q.delete(); wr_total = 0; rd_total = 0; m_ovf = 0; m_unf = 0; m_valid = 0;
        check_state();
        @(negedge clock);
        reset = 1'b0; pop = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        n_chk = 0; n_pass = 0;
        do_reset(1'b0);
        step(1'b1, 1'b0, {16{8'hA5}});
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 128'h1234);
        step(1'b0, 1'b1, '0);
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, DW'(32'hDEAD));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, rnd());
        for (int i = 0; i < 5000; i++) step(1'b1, 1'b1, rnd());
        for (int i = q.size(); i < DEPTH; i++) step(1'b1, 1'b0, rnd());
        step(1'b1, 1'b1, rnd());
        step(1'b1, 1'b0, rnd());
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 3000; i++) step(($urandom % 4) != 0, ($urandom % 4) != 0, rnd());
        step(1'b1, 1'b0, rnd());
        do_reset(1'b1);
        for (int i = 0; i < 600; i++) step(($urandom % 3) != 0, ($urandom % 3) == 0, rnd());
        for (int i = 0; i < 600; i++) step(($urandom % 3) == 0, ($urandom % 3) != 0, rnd());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
